// File: rtl/hgw_abs_acc_if.sv
// Sample/control bundle for the accumulate-and-dump stage.
// master drives samples and window control; slave returns window results.
interface hgw_abs_acc_if #(
    parameter int unsigned I_W   = 16,
    parameter int unsigned LEN_W = 8,
    parameter int unsigned O_W   = I_W + LEN_W
) ();

    logic             i_vld;
    logic [I_W-1:0]   i_dat;
    logic [LEN_W-1:0] win_len;
    logic             i_clr;
    logic             o_vld;
    logic [O_W-1:0]   o_sum;
    logic [I_W-1:0]   o_peak;
    logic             o_busy;

    modport master (
        output i_vld, i_dat, win_len, i_clr,
        input  o_vld, o_sum, o_peak, o_busy
    );

    modport slave (
        input  i_vld, i_dat, win_len, i_clr,
        output o_vld, o_sum, o_peak, o_busy
    );

endinterface

// File: rtl/hgw_abs_acc.sv
// Windowed magnitude accumulator: sums win_len samples and dumps one sum per window.
// Optional peak tracking is built only when HGW_ABS_ACC_PEAK_EN is defined.
module hgw_abs_acc #(
    parameter int unsigned I_W   = 16,
    parameter int unsigned LEN_W = 8,
    parameter int unsigned O_W   = I_W + LEN_W
) (
    input logic          clk,
    input logic          rst,
    hgw_abs_acc_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StAcc} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [O_W-1:0]   acc_q, acc_d;
    logic [O_W-1:0]   sum_q;
    logic             vld_q;
    logic             dump;
    logic [LEN_W-1:0] len_eff;

    // A zero window length behaves as a single-sample window.
    assign len_eff = (bus.win_len == '0) ? LEN_W'(1) : bus.win_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dump    = 1'b0;
        if (bus.i_clr) begin
            state_d = StIdle;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (bus.i_vld) begin
            unique case (state_q)
                StIdle: begin
                    len_d = len_eff;
                    acc_d = O_W'(bus.i_dat);
                    cnt_d = LEN_W'(1);
                    if (len_eff == LEN_W'(1)) begin
                        dump = 1'b1;
                    end else begin
                        state_d = StAcc;
                    end
                end
                StAcc: begin
                    acc_d = acc_q + O_W'(bus.i_dat);
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) begin
                        dump    = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Dump register: o_sum holds until the next completed window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            sum_q <= '0;
        end else begin
            vld_q <= dump;
            if (dump) begin
                sum_q <= acc_d;
            end
        end
    end

    always_comb begin
        bus.o_vld  = vld_q;
        bus.o_sum  = sum_q;
        bus.o_busy = (state_q == StAcc);
    end

`ifdef HGW_ABS_ACC_PEAK_EN
    logic [I_W-1:0] pk_acc_q, pk_acc_d;
    logic [I_W-1:0] peak_q;

    always_comb begin
        pk_acc_d = pk_acc_q;
        if (bus.i_clr) begin
            pk_acc_d = '0;
        end else if (bus.i_vld) begin
            if (state_q == StIdle || bus.i_dat > pk_acc_q) begin
                pk_acc_d = bus.i_dat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pk_acc_q <= '0;
            peak_q   <= '0;
        end else begin
            pk_acc_q <= pk_acc_d;
            if (dump) begin
                peak_q <= pk_acc_d;
            end
        end
    end

    assign bus.o_peak = peak_q;
`else
    assign bus.o_peak = '0;
`endif

endmodule

// File: tb/tb_hgw_abs_acc.sv
// Bench for hgw_abs_acc: directed plan steps plus random traffic against a queue-based window model.
module tb_hgw_abs_acc;

    localparam int unsigned I_W   = 16;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned O_W   = I_W + LEN_W;

    logic clk = 1'b0;
    logic rst;

    hgw_abs_acc_if #(.I_W(I_W), .LEN_W(LEN_W), .O_W(O_W)) bus ();

    hgw_abs_acc #(.I_W(I_W), .LEN_W(LEN_W), .O_W(O_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: the open window is just the list of samples accepted so far.
    int unsigned win[$];
    int unsigned cur_len;
    logic        exp_vld  = 1'b0;
    logic [31:0] exp_sum  = '0;
    logic [31:0] exp_peak = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        win.delete();
        exp_vld  = 1'b0;
        exp_sum  = '0;
        exp_peak = '0;
    endtask

    task automatic model_update();
        int unsigned s;
        int unsigned m;
        exp_vld = 1'b0;
        if (bus.i_clr) begin
            win.delete();
        end else if (bus.i_vld) begin
            if (win.size() == 0) cur_len = (bus.win_len == 0) ? 1 : int'(bus.win_len);
            win.push_back(int'(bus.i_dat));
            if (win.size() == cur_len) begin
                s = 0;
                m = 0;
                foreach (win[k]) begin
                    s += win[k];
                    if (win[k] > m) m = win[k];
                end
                exp_vld = 1'b1;
                exp_sum = s;
`ifdef HGW_ABS_ACC_PEAK_EN
                exp_peak = m;
`endif
                win.delete();
            end
        end
    endtask

    task automatic check_all();
        check("o_vld", 32'(bus.o_vld), 32'(exp_vld));
        check("o_sum", 32'(bus.o_sum), exp_sum);
        check("o_busy", 32'(bus.o_busy), 32'(win.size() != 0));
        check("o_peak", 32'(bus.o_peak), exp_peak);
    endtask

    task automatic step(input logic v, input logic [I_W-1:0] d, input logic c);
        @(negedge clk);
        bus.i_vld = v;
        bus.i_dat = d;
        bus.i_clr = c;
        @(posedge clk);
        cyc++;
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_vld   = 1'b0;
        bus.i_dat   = '0;
        bus.win_len = '0;
        bus.i_clr   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Window of 4, two back-to-back windows.
        bus.win_len = 8'd4;
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0);
        step(1'b0, '0, 1'b0);
        check("sum_26", 32'(bus.o_sum), 32'd26);

        // Length 0 and 1 both dump every sample.
        bus.win_len = 8'd0;
        step(1'b1, 16'd7, 1'b0);
        bus.win_len = 8'd1;
        step(1'b1, 16'd9, 1'b0);
        step(1'b0, '0, 1'b0);

        // Largest window at full-scale input.
        bus.win_len = 8'd255;
        for (int i = 0; i < 255; i++) step(1'b1, 16'hFFFF, 1'b0);
        check("sum_max", 32'(bus.o_sum), 32'h00FEFF01);
        bus.win_len = 8'd3;
        for (int i = 0; i < 3; i++) step(1'b1, 16'h8000, 1'b0);
        check("sum_top", 32'(bus.o_sum), 32'h00018000);

        // Gaps mid-window, and win_len change ignored until the next window.
        bus.win_len = 8'd3;
        step(1'b1, 16'd5, 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);
        bus.win_len = 8'd2;
        step(1'b1, 16'd6, 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);
        step(1'b1, 16'd7, 1'b0);
        check("sum_gap", 32'(bus.o_sum), 32'd18);
        step(1'b0, '0, 1'b0);

        // Clear aborts a window and swallows the coincident sample.
        bus.win_len = 8'd4;
        step(1'b1, 16'd100, 1'b0);
        step(1'b1, 16'd200, 1'b0);
        step(1'b1, 16'd300, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 16'd1, 1'b0);
        check("sum_clr", 32'(bus.o_sum), 32'd4);
        step(1'b0, '0, 1'b0);

        // Peak case (o_peak expected 0 when the feature is not built).
        bus.win_len = 8'd3;
        step(1'b1, 16'd3, 1'b0);
        step(1'b1, 16'd9, 1'b0);
        step(1'b1, 16'd4, 1'b0);
        step(1'b0, '0, 1'b0);

        // Random traffic with short windows, stray clears and win_len churn.
        for (int i = 0; i < 400; i++) begin
            bus.win_len = 8'($urandom_range(0, 6));
            step(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 24) == 0));
        end
        step(1'b0, '0, 1'b1);

        // Asynchronous reset in the middle of a window.
        bus.win_len = 8'd4;
        for (int i = 0; i < 4; i++) step(1'b1, 16'd50, 1'b0);
        step(1'b1, 16'd60, 1'b0);
        step(1'b1, 16'd70, 1'b0);
        @(negedge clk);
        bus.i_vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 16'd5, 1'b0);
        step(1'b0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
